// File: rtl/alu_issue_queue.sv
// alu_issue_queue -- reservation station for the ALU functional unit.
//
// Buffers dispatched ALU ops in a collapsing queue (entry 0 oldest, valid
// entries packed into 0..count-1), captures missing source operands from the
// result broadcast bus, and issues the oldest entry whose two sources are
// both ready. The issue bundle feeds the ALU FU, which always accepts.
//
// Ports
//   clk, resetn          clock; synchronous active-low reset (priority over flush)
//   flush                discard every entry; same-cycle dispatch/wakeup dropped
//   disp_*               dispatch request from rename: op, status word, ROB tag,
//                        and per-source ready bit, producer tag and value
//   bc_valid/tag/data    result broadcast used for operand wakeup
//   iss_*                issue bundle to the ALU FU; all zero when nothing issues
//   count                number of occupied entries
//
// Dispatch handshake: a dispatch is accepted on a rising edge where
// disp_valid & disp_ready are both high. disp_ready depends only on registered
// state (count < DEPTH), so a same-cycle issue never opens a slot; a request
// seen with disp_ready low is ignored and the upstream keeps holding it.

`ifndef INST_STATE_WD
`define INST_STATE_WD 16
`endif

module alu_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int CNT_WD = 4,
  parameter int TAG_WD = 5
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [11:0]               disp_op,
  input  logic [`INST_STATE_WD-1:0] disp_status,
  input  logic [TAG_WD-1:0]         disp_tag,
  input  logic                      disp_s1_rdy,
  input  logic [TAG_WD-1:0]         disp_s1_tag,
  input  logic [31:0]               disp_s1_data,
  input  logic                      disp_s2_rdy,
  input  logic [TAG_WD-1:0]         disp_s2_tag,
  input  logic [31:0]               disp_s2_data,
  input  logic                      bc_valid,
  input  logic [TAG_WD-1:0]         bc_tag,
  input  logic [31:0]               bc_data,
  output logic                      iss_ready,
  output logic [11:0]               iss_op,
  output logic [`INST_STATE_WD-1:0] iss_status,
  output logic [31:0]               iss_rdata1,
  output logic [31:0]               iss_rdata2,
  output logic [TAG_WD-1:0]         iss_tag,
  output logic [CNT_WD-1:0]         count
);

  localparam int IDX_WD = $clog2(DEPTH);

  typedef struct packed {
    logic [11:0]               op;
    logic [`INST_STATE_WD-1:0] status;
    logic [TAG_WD-1:0]         tag;
    logic                      s1_rdy;
    logic [TAG_WD-1:0]         s1_tag;
    logic [31:0]               s1_data;
    logic                      s2_rdy;
    logic [TAG_WD-1:0]         s2_tag;
    logic [31:0]               s2_data;
  } entry_t;

  entry_t              ent_q [DEPTH];
  entry_t              ent_d [DEPTH];
  entry_t              woke  [DEPTH];
  entry_t              disp_ent;
  logic [CNT_WD-1:0]   count_q;
  logic [CNT_WD-1:0]   count_d;
  logic                issue;
  logic [IDX_WD-1:0]   sel;
  logic                disp_fire;
  logic [CNT_WD-1:0]   wr_idx;

  // Capture a broadcast value into any source still waiting on that tag.
  function automatic entry_t wake(input entry_t e, input logic v,
                                  input logic [TAG_WD-1:0] t, input logic [31:0] d);
    entry_t r;
    r = e;
    if (v && !e.s1_rdy && (e.s1_tag == t)) begin
      r.s1_rdy  = 1'b1;
      r.s1_data = d;
    end
    if (v && !e.s2_rdy && (e.s2_tag == t)) begin
      r.s2_rdy  = 1'b1;
      r.s2_data = d;
    end
    return r;
  endfunction

  // Oldest-ready select: scanning from the top down leaves the lowest hit.
  always_comb begin
    issue = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_WD'(i) < count_q) && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        issue = 1'b1;
        sel   = IDX_WD'(i);
      end
    end
  end

  always_comb begin
    iss_ready  = issue;
    iss_op     = '0;
    iss_status = '0;
    iss_tag    = '0;
    iss_rdata1 = '0;
    iss_rdata2 = '0;
    if (issue) begin
      iss_op     = ent_q[sel].op;
      iss_status = ent_q[sel].status;
      iss_tag    = ent_q[sel].tag;
      iss_rdata1 = ent_q[sel].s1_data;
      iss_rdata2 = ent_q[sel].s2_data;
    end
  end

  assign disp_ready = (count_q < CNT_WD'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  // The issued slot disappears this edge, so the new entry lands one lower.
  assign wr_idx     = count_q - CNT_WD'(issue);
  assign count_d    = count_q + CNT_WD'(disp_fire) - CNT_WD'(issue);
  assign count      = count_q;

  always_comb begin
    disp_ent.op      = disp_op;
    disp_ent.status  = disp_status;
    disp_ent.tag     = disp_tag;
    disp_ent.s1_rdy  = disp_s1_rdy;
    disp_ent.s1_tag  = disp_s1_tag;
    disp_ent.s1_data = disp_s1_data;
    disp_ent.s2_rdy  = disp_s2_rdy;
    disp_ent.s2_tag  = disp_s2_tag;
    disp_ent.s2_data = disp_s2_data;
    disp_ent         = wake(disp_ent, bc_valid, bc_tag, bc_data);

    // Wakeup is applied before the collapse so shifting entries keep the capture.
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (CNT_WD'(i) < count_q) begin
        woke[i] = wake(ent_q[i], bc_valid, bc_tag, bc_data);
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = woke[i];
    end
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_WD'(i) >= sel) begin
          ent_d[i] = woke[i + 1];
        end
      end
    end
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_WD'(i) == wr_idx) begin
          ent_d[i] = disp_ent;
        end
      end
    end
  end

  // Only ready bits and count are cleared; payload fields beyond count are
  // never selected so they may keep stale values.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].s1_rdy <= 1'b0;
        ent_q[i].s2_rdy <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Testbench for alu_issue_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the reservation station.

`ifndef INST_STATE_WD
`define INST_STATE_WD 16
`endif

module tb_alu_issue_queue;

  localparam int DEPTH = 8;
  localparam int SW    = `INST_STATE_WD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, flush;
  logic          disp_valid, disp_ready;
  logic [11:0]   disp_op;
  logic [SW-1:0] disp_status;
  logic [4:0]    disp_tag;
  logic          disp_s1_rdy, disp_s2_rdy;
  logic [4:0]    disp_s1_tag, disp_s2_tag;
  logic [31:0]   disp_s1_data, disp_s2_data;
  logic          bc_valid;
  logic [4:0]    bc_tag;
  logic [31:0]   bc_data;
  logic          iss_ready;
  logic [11:0]   iss_op;
  logic [SW-1:0] iss_status;
  logic [31:0]   iss_rdata1, iss_rdata2;
  logic [4:0]    iss_tag;
  logic [3:0]    count;

  alu_issue_queue #(.DEPTH(8), .CNT_WD(4), .TAG_WD(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_status(disp_status), .disp_tag(disp_tag),
    .disp_s1_rdy(disp_s1_rdy), .disp_s1_tag(disp_s1_tag), .disp_s1_data(disp_s1_data),
    .disp_s2_rdy(disp_s2_rdy), .disp_s2_tag(disp_s2_tag), .disp_s2_data(disp_s2_data),
    .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
    .iss_ready(iss_ready), .iss_op(iss_op), .iss_status(iss_status),
    .iss_rdata1(iss_rdata1), .iss_rdata2(iss_rdata2), .iss_tag(iss_tag),
    .count(count)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [11:0]   op;
    logic [SW-1:0] st;
    logic [4:0]    tag;
    bit            r1;
    logic [4:0]    t1;
    logic [31:0]   d1;
    bit            r2;
    logic [4:0]    t2;
    logic [31:0]   d2;
  } ment_t;

  typedef struct packed {
    logic          dr;
    logic [3:0]    cnt;
    logic          ir;
    logic [11:0]   op;
    logic [SW-1:0] st;
    logic [4:0]    tag;
    logic [31:0]   d1;
    logic [31:0]   d2;
  } exp_t;

  localparam int EW = $bits(exp_t);

  ment_t      mq[$];
  logic [EW-1:0] exp_q[$];

  function automatic ment_t mwake(input ment_t e);
    ment_t r = e;
    if (bc_valid && !r.r1 && r.t1 == bc_tag) begin r.r1 = 1; r.d1 = bc_data; end
    if (bc_valid && !r.r2 && r.t2 == bc_tag) begin r.r2 = 1; r.d2 = bc_data; end
    return r;
  endfunction

  function automatic int oldest_ready();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  // Advance the model on each edge, then record what the DUT must show next.
  always @(posedge clk) begin
    exp_t e;
    int   s;
    bit   fire;
    ment_t n;
    if (!resetn || flush) begin
      mq.delete();
    end else begin
      s    = oldest_ready();
      fire = disp_valid && (mq.size() < DEPTH);
      if (s >= 0) mq.delete(s);
      foreach (mq[i]) mq[i] = mwake(mq[i]);
      if (fire) begin
        n.op = disp_op; n.st = disp_status; n.tag = disp_tag;
        n.r1 = disp_s1_rdy; n.t1 = disp_s1_tag; n.d1 = disp_s1_data;
        n.r2 = disp_s2_rdy; n.t2 = disp_s2_tag; n.d2 = disp_s2_data;
        mq.push_back(mwake(n));
      end
    end
    e     = '0;
    e.dr  = (mq.size() < DEPTH);
    e.cnt = 4'(mq.size());
    s     = oldest_ready();
    if (s >= 0) begin
      e.ir = 1'b1; e.op = mq[s].op; e.st = mq[s].st; e.tag = mq[s].tag;
      e.d1 = mq[s].d1; e.d2 = mq[s].d2;
    end
    exp_q.push_back(EW'(e));
  end

  // Compare process: one expected bundle per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("disp_ready", 64'(disp_ready), 64'(e.dr));
      chk("count",      64'(count),      64'(e.cnt));
      chk("iss_ready",  64'(iss_ready),  64'(e.ir));
      chk("iss_op",     64'(iss_op),     64'(e.op));
      chk("iss_status", 64'(iss_status), 64'(e.st));
      chk("iss_tag",    64'(iss_tag),    64'(e.tag));
      chk("iss_rdata1", 64'(iss_rdata1), 64'(e.d1));
      chk("iss_rdata2", 64'(iss_rdata2), 64'(e.d2));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    disp_valid = 1'b0; bc_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic set_disp(input logic [11:0] op, input logic [4:0] tag,
                          input bit r1, input logic [4:0] t1, input logic [31:0] d1,
                          input bit r2, input logic [4:0] t2, input logic [31:0] d2);
    disp_valid = 1'b1; disp_op = op; disp_status = SW'($urandom); disp_tag = tag;
    disp_s1_rdy = r1; disp_s1_tag = t1; disp_s1_data = d1;
    disp_s2_rdy = r2; disp_s2_tag = t2; disp_s2_data = d2;
  endtask

  task automatic set_bc(input logic [4:0] tag, input logic [31:0] data);
    bc_valid = 1'b1; bc_tag = tag; bc_data = data;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0; idle();
    disp_op = '0; disp_status = '0; disp_tag = '0;
    disp_s1_rdy = 0; disp_s1_tag = '0; disp_s1_data = '0;
    disp_s2_rdy = 0; disp_s2_tag = '0; disp_s2_data = '0;
    bc_tag = '0; bc_data = '0;
    repeat (3) nxt();
    resetn = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_iss_ready", 64'(iss_ready), 64'd0);

    // 1: ready dispatch issues next cycle
    set_disp(12'h001, 5'd3, 1, 5'd0, 32'd5, 1, 5'd0, 32'd7);
    nxt(); idle();
    chk("t1_iss_ready", 64'(iss_ready), 64'd1);
    chk("t1_rdata1", 64'(iss_rdata1), 64'd5);
    chk("t1_rdata2", 64'(iss_rdata2), 64'd7);
    chk("t1_tag", 64'(iss_tag), 64'd3);
    nxt();
    chk("t1_count0", 64'(count), 64'd0);

    // 2: younger ready entry bypasses older waiting one, then wakeup
    set_disp(12'h002, 5'd10, 0, 5'd9, 32'd0, 1, 5'd0, 32'd1);
    nxt();
    set_disp(12'h004, 5'd11, 1, 5'd0, 32'd2, 1, 5'd0, 32'd3);
    nxt(); idle();
    chk("t2_b_first", 64'(iss_tag), 64'd11);
    set_bc(5'd9, 32'hDEAD);
    nxt(); idle();
    chk("t2_a_ready", 64'(iss_ready), 64'd1);
    chk("t2_a_tag", 64'(iss_tag), 64'd10);
    chk("t2_a_rdata1", 64'(iss_rdata1), 64'hDEAD);
    nxt();

    // 3: dispatch-cycle bypass
    set_disp(12'h008, 5'd12, 1, 5'd0, 32'd1, 0, 5'd4, 32'd0);
    set_bc(5'd4, 32'h55);
    nxt(); idle();
    chk("t3_ready", 64'(iss_ready), 64'd1);
    chk("t3_rdata2", 64'(iss_rdata2), 64'h55);
    chk("t3_tag", 64'(iss_tag), 64'd12);
    nxt();

    // 4: fill, reject when full, wake middle entry
    for (int k = 0; k < 8; k++) begin
      set_disp(12'h010, 5'(16 + k), 0, 5'(8 + k), 32'd0, 1, 5'd0, 32'(k));
      nxt();
    end
    idle();
    chk("t4_full_count", 64'(count), 64'd8);
    chk("t4_full_dr", 64'(disp_ready), 64'd0);
    set_disp(12'h020, 5'd31, 1, 5'd0, 32'd0, 1, 5'd0, 32'd0);
    nxt(); idle();
    chk("t4_ignored", 64'(count), 64'd8);
    set_bc(5'd10, 32'h222);
    nxt(); idle();
    chk("t4_e2_tag", 64'(iss_tag), 64'd18);
    chk("t4_e2_rdata1", 64'(iss_rdata1), 64'h222);
    nxt();
    chk("t4_count7", 64'(count), 64'd7);
    chk("t4_dr1", 64'(disp_ready), 64'd1);
    set_bc(5'd11, 32'h333);
    nxt(); idle();
    chk("t4_e3_tag", 64'(iss_tag), 64'd19);
    flush = 1'b1;
    nxt(); idle();

    // 5: simultaneous issue and dispatch
    for (int k = 0; k < 5; k++) begin
      set_disp(12'h040, 5'(16 + k), 0, (k == 0) ? 5'd7 : 5'd8, 32'd0, 1, 5'd0, 32'(k));
      nxt();
    end
    idle(); set_bc(5'd7, 32'h77);
    nxt(); idle();
    chk("t5_e0_tag", 64'(iss_tag), 64'd16);
    set_disp(12'h080, 5'd21, 0, 5'd8, 32'd0, 1, 5'd0, 32'd9);
    nxt(); idle();
    chk("t5_count5", 64'(count), 64'd5);
    set_bc(5'd8, 32'h88);
    nxt(); idle();
    for (int k = 0; k < 5; k++) begin
      chk("t5_order", 64'(iss_tag), 64'(17 + k));
      nxt();
    end
    chk("t5_drained", 64'(count), 64'd0);

    // 6: flush with concurrent dispatch and wakeup
    for (int k = 0; k < 6; k++) begin
      set_disp(12'h100, 5'(k), 0, 5'd30, 32'd0, 1, 5'd0, 32'd0);
      nxt();
    end
    flush = 1'b1;
    set_disp(12'h200, 5'd6, 1, 5'd0, 32'd1, 1, 5'd0, 32'd2);
    set_bc(5'd30, 32'h30);
    nxt(); idle();
    chk("t6_count0", 64'(count), 64'd0);
    chk("t6_iss0", 64'(iss_ready), 64'd0);
    set_bc(5'd30, 32'h31);
    nxt(); idle();
    nxt();
    chk("t6_no_stale", 64'(iss_ready), 64'd0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      disp_valid   = ($urandom_range(0, 2) != 0);
      disp_op      = 12'(1 << $urandom_range(0, 11));
      disp_status  = SW'($urandom);
      disp_tag     = 5'($urandom_range(0, 31));
      disp_s1_rdy  = ($urandom_range(0, 2) != 0);
      disp_s1_tag  = 5'($urandom_range(0, 7));
      disp_s1_data = $urandom;
      disp_s2_rdy  = ($urandom_range(0, 2) != 0);
      disp_s2_tag  = 5'($urandom_range(0, 7));
      disp_s2_data = $urandom;
      bc_valid     = ($urandom_range(0, 2) == 0);
      bc_tag       = 5'($urandom_range(0, 7));
      bc_data      = $urandom;
      flush        = ($urandom_range(0, 99) == 0);
      resetn       = ($urandom_range(0, 499) != 0);
      nxt();
    end
    resetn = 1'b1; idle();
    repeat (3) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
